// File: rtl/n64_bus_arbiter_pkg.sv
// Shared types and constants for the N64 internal bus arbiter.
package n64_bus_arbiter_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } e_arb_state;

  localparam logic [15:0] ARB_TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/n64_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting, unmasked index at or after pointer (wrapping).
module n64_bus_arbiter_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     request,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] pointer,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the pointer and keep the first hit.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = IDX_W'((int'(pointer) + i) % N);
      if (!valid && request[cand_s] && mask[cand_s]) begin
        valid = 1'b1;
        index = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/n64_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto one N64 bus slave port, with class priority,
// round-robin within a class and a watchdog that aborts a stuck slave.
module n64_bus_arbiter
  import n64_bus_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ       = 3,
  parameter int                 ADDR_W        = 32,
  parameter int                 DATA_W        = 16,
  parameter int                 ID_W          = 3,
  parameter logic [NUM_REQ-1:0] PRIORITY_MASK = 3'b001,
  parameter int                 TIMEOUT       = 1023,
  localparam int                IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_request,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_request,
  output logic                      mem_write,
  output logic [ID_W-1:0]           mem_id,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [IDX_W-1:0]          grant_owner,
  output logic                      busy,
  output logic                      timeout_error,
  input  logic                      clear_error
);

  e_arb_state state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_pointer_r, rr_pointer_nxt_s, owner_nxt_s, next_ptr_s;
  logic [15:0]        watchdog_r, watchdog_nxt_s;
  logic [NUM_REQ-1:0] ack_nxt_s, req_eff_s;
  logic [DATA_W-1:0]  rdata_nxt_s, wdata_nxt_s;
  logic [ADDR_W-1:0]  addr_nxt_s, addr_raw_s;
  logic [ID_W-1:0]    id_nxt_s;
  logic               mreq_nxt_s, write_nxt_s, busy_nxt_s, err_nxt_s;
  logic               hi_valid_s, all_valid_s;
  logic [IDX_W-1:0]   hi_index_s, all_index_s, winner_s;

  // The requester acked this cycle has not yet seen its ack, so keep it out of arbitration.
  assign req_eff_s = req_request & ~req_ack;

  n64_bus_arbiter_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_hi (
    .request(req_eff_s), .mask(PRIORITY_MASK), .pointer(rr_pointer_r),
    .valid(hi_valid_s), .index(hi_index_s)
  );

  n64_bus_arbiter_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_all (
    .request(req_eff_s), .mask({NUM_REQ{1'b1}}), .pointer(rr_pointer_r),
    .valid(all_valid_s), .index(all_index_s)
  );

  assign winner_s   = hi_valid_s ? hi_index_s : all_index_s;
  assign addr_raw_s = req_address[winner_s*ADDR_W +: ADDR_W];
  assign next_ptr_s = (grant_owner == IDX_W'(NUM_REQ - 1)) ? '0 : grant_owner + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s      = state_r;
    rr_pointer_nxt_s = rr_pointer_r;
    watchdog_nxt_s   = watchdog_r;
    owner_nxt_s      = grant_owner;
    ack_nxt_s        = '0;
    rdata_nxt_s      = req_rdata;
    mreq_nxt_s       = mem_request;
    write_nxt_s      = mem_write;
    id_nxt_s         = mem_id;
    addr_nxt_s       = mem_address;
    wdata_nxt_s      = mem_wdata;
    busy_nxt_s       = busy;
    err_nxt_s        = timeout_error & ~clear_error;
    case (state_r)
      S_IDLE: begin
        if (all_valid_s) begin
          owner_nxt_s    = winner_s;
          write_nxt_s    = req_write[winner_s];
          id_nxt_s       = req_id[winner_s*ID_W +: ID_W];
          addr_nxt_s     = {addr_raw_s[ADDR_W-1:1], 1'b0};
          wdata_nxt_s    = req_wdata[winner_s*DATA_W +: DATA_W];
          mreq_nxt_s     = 1'b1;
          busy_nxt_s     = 1'b1;
          watchdog_nxt_s = 16'd0;
          state_nxt_s    = S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mreq_nxt_s             = 1'b0;
          ack_nxt_s[grant_owner] = 1'b1;
          rdata_nxt_s            = mem_rdata;
          rr_pointer_nxt_s       = next_ptr_s;
          busy_nxt_s             = 1'b0;
          state_nxt_s            = S_IDLE;
        end else if (watchdog_r == 16'(TIMEOUT)) begin
          mreq_nxt_s             = 1'b0;
          ack_nxt_s[grant_owner] = 1'b1;
          rdata_nxt_s            = DATA_W'(ARB_TIMEOUT_RDATA);
          err_nxt_s              = 1'b1;
          rr_pointer_nxt_s       = next_ptr_s;
          busy_nxt_s             = 1'b0;
          state_nxt_s            = S_IDLE;
        end else if (watchdog_r != 16'hFFFF) begin
          watchdog_nxt_s = watchdog_r + 16'd1;
        end else begin
          watchdog_nxt_s = watchdog_r;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      rr_pointer_r  <= '0;
      watchdog_r    <= 16'd0;
      grant_owner   <= '0;
      req_ack       <= '0;
      req_rdata     <= '0;
      mem_request   <= 1'b0;
      mem_write     <= 1'b0;
      mem_id        <= '0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rr_pointer_r  <= rr_pointer_nxt_s;
      watchdog_r    <= watchdog_nxt_s;
      grant_owner   <= owner_nxt_s;
      req_ack       <= ack_nxt_s;
      req_rdata     <= rdata_nxt_s;
      mem_request   <= mreq_nxt_s;
      mem_write     <= write_nxt_s;
      mem_id        <= id_nxt_s;
      mem_address   <= addr_nxt_s;
      mem_wdata     <= wdata_nxt_s;
      busy          <= busy_nxt_s;
      timeout_error <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_n64_bus_arbiter.sv
// Directed self-checking bench for n64_bus_arbiter (3 requesters, TIMEOUT = 15).
module tb_n64_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_request, req_write, req_ack;
  logic [8:0]  req_id;
  logic [95:0] req_address;
  logic [47:0] req_wdata;
  logic [15:0] req_rdata, mem_wdata, mem_rdata;
  logic        mem_request, mem_write, mem_ack, busy, timeout_error, clear_error;
  logic [2:0]  mem_id;
  logic [31:0] mem_address;
  logic [1:0]  grant_owner;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n64_bus_arbiter #(
    .NUM_REQ(3), .ADDR_W(32), .DATA_W(16), .ID_W(3), .PRIORITY_MASK(3'b001), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_request(req_request), .req_write(req_write),
    .req_id(req_id), .req_address(req_address), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_rdata(req_rdata), .mem_request(mem_request), .mem_write(mem_write), .mem_id(mem_id),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_owner(grant_owner), .busy(busy), .timeout_error(timeout_error), .clear_error(clear_error)
  );

  task automatic set_req(input int i, input logic w, input logic [2:0] id,
                         input logic [31:0] addr, input logic [15:0] wd);
    req_write[i]            = w;
    req_id[i*3 +: 3]        = id;
    req_address[i*32 +: 32] = addr;
    req_wdata[i*16 +: 16]   = wd;
    req_request[i]          = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = mem_request;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_request = '0; req_write = '0; req_id = '0; req_address = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; clear_error = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ack, mem_request, busy, timeout_error, grant_owner, req_rdata, mem_address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b mreq=%b busy=%b err=%b owner=%0d rdata=%h addr=%h, required all 0",
               req_ack, mem_request, busy, timeout_error, grant_owner, req_rdata, mem_address);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'h1000_0002, 16'h0000);
    @(negedge clk);
    checks++;
    if ({mem_request, busy, mem_write, mem_id, grant_owner} !== {1'b1, 1'b1, 1'b0, 3'd0, 2'd0} ||
        mem_address !== 32'h1000_0002) begin
      errors++;
      $display("FAIL single_issue: mreq=%b busy=%b wr=%b id=%0d owner=%0d addr=%h, required 1 1 0 0 0 10000002",
               mem_request, busy, mem_write, mem_id, grant_owner, mem_address);
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0; req_request[0] = 1'b0;
    checks++;
    if (req_ack !== 3'b001 || req_rdata !== 16'hBEEF || busy !== 1'b0 || mem_request !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack=%b rdata=%h busy=%b mreq=%b, required 001 beef 0 0",
               req_ack, req_rdata, busy, mem_request);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== 3'b000 || mem_request !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_pulse: ack=%b mreq=%b, required 000 0", req_ack, mem_request);
    end
  endtask

  task automatic test_round_robin();
    int exp_owner [4] = '{1, 2, 1, 2};
    bit ok;
    @(negedge clk);
    set_req(1, 1'b1, 3'd2, 32'h0000_0201, 16'h1111);
    set_req(2, 1'b0, 3'd3, 32'h0000_0300, 16'h2222);
    for (int g = 0; g < 4; g++) begin
      wait_req(ok);
      checks++;
      if (!ok || grant_owner !== 2'(exp_owner[g]) ||
          mem_address !== ((exp_owner[g] == 1) ? 32'h0000_0200 : 32'h0000_0300) ||
          mem_write !== (exp_owner[g] == 1) ||
          mem_wdata !== ((exp_owner[g] == 1) ? 16'h1111 : 16'h2222)) begin
        errors++;
        $display("FAIL rr_grant%0d: mreq=%b owner=%0d addr=%h wr=%b wdata=%h, required owner %0d",
                 g, mem_request, grant_owner, mem_address, mem_write, mem_wdata, exp_owner[g]);
      end
      mem_ack = 1'b1; mem_rdata = 16'h0100 + 16'(g);
      @(negedge clk);
      mem_ack = 1'b0;
      if (g == 3) req_request = 3'b000;
      checks++;
      if (req_ack !== (3'b001 << exp_owner[g]) || req_rdata !== 16'h0100 + 16'(g)) begin
        errors++;
        $display("FAIL rr_ack%0d: ack=%b rdata=%h, required %b %h",
                 g, req_ack, req_rdata, 3'b001 << exp_owner[g], 16'h0100 + 16'(g));
      end
    end
  endtask

  task automatic test_priority();
    int exp_owner [3] = '{1, 0, 2};
    bit ok;
    @(negedge clk);
    set_req(1, 1'b0, 3'd1, 32'h0000_0510, 16'h0000);
    set_req(2, 1'b0, 3'd1, 32'h0000_0520, 16'h0000);
    for (int g = 0; g < 3; g++) begin
      wait_req(ok);
      if (g == 0) begin
        set_req(0, 1'b0, 3'd4, 32'h0000_0400, 16'h0000);
        repeat (2) @(negedge clk);
      end
      checks++;
      if (!ok || grant_owner !== 2'(exp_owner[g]) ||
          mem_address !== ((g == 0) ? 32'h510 : (g == 1) ? 32'h400 : 32'h520)) begin
        errors++;
        $display("FAIL prio_grant%0d: mreq=%b owner=%0d addr=%h, required owner %0d",
                 g, mem_request, grant_owner, mem_address, exp_owner[g]);
      end
      mem_ack = 1'b1; mem_rdata = 16'h0A0A;
      @(negedge clk);
      mem_ack = 1'b0;
      req_request[exp_owner[g]] = 1'b0;
      checks++;
      if (req_ack !== (3'b001 << exp_owner[g])) begin
        errors++;
        $display("FAIL prio_ack%0d: ack=%b, required %b", g, req_ack, 3'b001 << exp_owner[g]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt = 0;
    @(negedge clk);
    set_req(1, 1'b0, 3'd1, 32'h0000_0700, 16'h0000);
    wait_req(ok);
    while (req_ack === 3'b000 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    req_request[1] = 1'b0;
    checks++;
    if (!ok || cnt != 16 || req_ack !== 3'b010 || req_rdata !== 16'hFFFF || timeout_error !== 1'b1 ||
        busy !== 1'b0 || mem_request !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: cycles=%0d ack=%b rdata=%h err=%b busy=%b mreq=%b, required 16 010 ffff 1 0 0",
               cnt, req_ack, req_rdata, timeout_error, busy, mem_request);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (req_ack !== 3'b000 || req_rdata !== 16'hFFFF || busy !== 1'b0 || mem_request !== 1'b0 ||
        timeout_error !== 1'b1) begin
      errors++;
      $display("FAIL late_ack_ignored: ack=%b rdata=%h busy=%b mreq=%b err=%b, required 000 ffff 0 0 1",
               req_ack, req_rdata, busy, mem_request, timeout_error);
    end
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    checks++;
    if (timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL clear_error: err=%b, required 0", timeout_error);
    end
  endtask

  task automatic test_coincident_ack();
    bit ok;
    @(negedge clk);
    set_req(2, 1'b0, 3'd6, 32'h0000_0800, 16'h0000);
    wait_req(ok);
    repeat (15) @(negedge clk);
    checks++;
    if (!ok || req_ack !== 3'b000 || mem_request !== 1'b1) begin
      errors++;
      $display("FAIL coincide_pending: ok=%b ack=%b mreq=%b, required 1 000 1", ok, req_ack, mem_request);
    end
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    @(negedge clk);
    mem_ack = 1'b0; req_request[2] = 1'b0;
    checks++;
    if (req_ack !== 3'b100 || req_rdata !== 16'hA5A5 || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL coincide_ack: ack=%b rdata=%h err=%b, required 100 a5a5 0",
               req_ack, req_rdata, timeout_error);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    @(negedge clk);
    set_req(1, 1'b0, 3'd5, 32'h0000_0900, 16'h0000);
    wait_req(ok);
    mem_ack = 1'b1; mem_rdata = 16'h0000;
    @(negedge clk);
    mem_ack = 1'b0; req_request[1] = 1'b0;
    @(negedge clk);
    set_req(1, 1'b0, 3'd5, 32'h0000_0900, 16'h0000);
    set_req(2, 1'b0, 3'd5, 32'h0000_0A00, 16'h0000);
    wait_req(ok);
    checks++;
    if (!ok || grant_owner !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_grant: mreq=%b owner=%0d, required 1 2", mem_request, grant_owner);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_request !== 1'b0 || busy !== 1'b0 || req_ack !== 3'b000 || grant_owner !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: mreq=%b busy=%b ack=%b owner=%0d, required 0 0 000 0",
               mem_request, busy, req_ack, grant_owner);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || grant_owner !== 2'd1 || mem_address !== 32'h0000_0900) begin
      errors++;
      $display("FAIL post_reset_grant: mreq=%b owner=%0d addr=%h, required 1 1 00000900",
               mem_request, grant_owner, mem_address);
    end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 1'b0; req_request = 3'b000;
    checks++;
    if (req_ack !== 3'b010 || req_rdata !== 16'h5555) begin
      errors++;
      $display("FAIL post_reset_ack: ack=%b rdata=%h, required 010 5555", req_ack, req_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority();
    test_timeout();
    test_coincident_ack();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
